// File: rtl/mm_pkg.sv
// Shared types, default sizes and address helper for the matrix-multiply feeder.
package mm_pkg;
  localparam int ACT_WIDTH_DEF = 16;
  localparam int N_DEF         = 2;
  localparam int K_DEF         = 2;
  localparam int MAX_PREC_DEF  = 8;
  localparam int AW_DEF        = 8;

  typedef enum logic [3:0] {
    IDLE, ACT_FETCH, ACT_WAIT, ACT_PUSH, W_FETCH, W_WAIT, W_PUSH, GAP, RUN, DONE
  } state_t;

  // Row r, reduction step k lives at r*K+k in both memories.
  function automatic int addr_of(input int r, input int k, input int kdim = K_DEF);
    return r * kdim + k;
  endfunction

  // Counter width that never collapses to zero bits for a size of one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mm_stage_fetch.sv
// Walks rows 0..N-1 for one reduction step, issues memory addresses and
// captures the one-cycle-late read data into an N-entry staging register.
module mm_stage_fetch
  import mm_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N     = 2,
  parameter int K     = 2,
  parameter int AW    = 8,
  parameter int KW    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch,
  input  logic [KW-1:0]      k,
  input  logic [WIDTH-1:0]   rd_data,
  output logic [AW-1:0]      rd_addr,
  output logic               last,
  output logic [N*WIDTH-1:0] stage
);
  localparam int RW = cnt_width(N);

  logic [RW-1:0] r;
  logic [RW-1:0] cap_idx;
  logic          cap_valid;

  // The capture pipeline trails the address by one cycle, so the final row
  // lands during the wait state that follows the fetch burst.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r         <= '0;
      cap_idx   <= '0;
      cap_valid <= 1'b0;
      stage     <= '0;
    end else begin
      cap_valid <= fetch;
      cap_idx   <= r;
      if (fetch) r <= last ? '0 : r + RW'(1);
      else       r <= '0;
      if (cap_valid) stage[int'(cap_idx)*WIDTH +: WIDTH] <= rd_data;
    end
  end

  assign last    = (r == RW'(N - 1));
  assign rd_addr = fetch ? AW'(addr_of(int'(r), int'(k), K)) : '0;
endmodule

// File: rtl/mm_feeder.sv
// Loads activations and bit-serial weights from memory into the systolic
// array FIFOs, then runs the array for K*precision cycles.
module mm_feeder
  import mm_pkg::*;
#(
  parameter int ACT_WIDTH = ACT_WIDTH_DEF,
  parameter int N         = N_DEF,
  parameter int K         = K_DEF,
  parameter int MAX_PREC  = MAX_PREC_DEF,
  parameter int AW        = AW_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [3:0]             precision,
  output logic [AW-1:0]          act_rd_addr,
  input  logic [ACT_WIDTH-1:0]   act_rd_data,
  output logic [AW-1:0]          w_rd_addr,
  input  logic [MAX_PREC-1:0]    w_rd_data,
  output logic [N*ACT_WIDTH-1:0] act_din,
  output logic                   wr_en_act,
  input  logic [N-1:0]           act_full,
  output logic [N-1:0]           w_din,
  output logic                   wr_en_w,
  input  logic [N-1:0]           w_full,
  output logic                   active,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);
  localparam int KW = cnt_width(K);
  localparam int PW = cnt_width(MAX_PREC);

  state_t          state, state_n;
  logic [KW-1:0]   k, k_n;
  logic [PW-1:0]   p, p_n;
  logic [3:0]      prec_q, prec_n;
  logic            gap, gap_n;
  logic            err_q, err_n;
  logic            act_last, w_last;
  logic [N*MAX_PREC-1:0] w_stage;
  logic [PW-1:0]   p_last;
  logic            k_last;
  logic            prec_ok;

  assign p_last  = PW'(prec_q - 4'd1);
  assign k_last  = (k == KW'(K - 1));
  assign prec_ok = (precision != 4'd0) && (int'(precision) <= MAX_PREC);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      k      <= '0;
      p      <= '0;
      prec_q <= '0;
      gap    <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      k      <= k_n;
      p      <= p_n;
      prec_q <= prec_n;
      gap    <= gap_n;
      err_q  <= err_n;
    end
  end

  // RUN reuses the k/p counters so it lasts exactly K*prec_q cycles.
  always_comb begin
    state_n   = state;
    k_n       = k;
    p_n       = p;
    prec_n    = prec_q;
    gap_n     = gap;
    err_n     = 1'b0;
    wr_en_act = 1'b0;
    wr_en_w   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (prec_ok) begin
            prec_n  = precision;
            k_n     = '0;
            p_n     = '0;
            gap_n   = 1'b0;
            state_n = ACT_FETCH;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      ACT_FETCH: if (act_last) state_n = ACT_WAIT;
      ACT_WAIT:  state_n = ACT_PUSH;
      ACT_PUSH: begin
        if (act_full == '0) begin
          wr_en_act = 1'b1;
          if (k_last) begin
            k_n     = '0;
            state_n = W_FETCH;
          end else begin
            k_n     = k + KW'(1);
            state_n = ACT_FETCH;
          end
        end
      end
      W_FETCH: if (w_last) state_n = W_WAIT;
      W_WAIT:  state_n = W_PUSH;
      W_PUSH: begin
        if (w_full == '0) begin
          wr_en_w = 1'b1;
          if (p == p_last) begin
            p_n = '0;
            if (k_last) begin
              k_n     = '0;
              state_n = GAP;
            end else begin
              k_n     = k + KW'(1);
              state_n = W_FETCH;
            end
          end else begin
            p_n = p + PW'(1);
          end
        end
      end
      GAP: begin
        gap_n = ~gap;
        if (gap) state_n = RUN;
      end
      RUN: begin
        if (p == p_last) begin
          p_n = '0;
          if (k_last) begin
            k_n     = '0;
            state_n = DONE;
          end else begin
            k_n = k + KW'(1);
          end
        end else begin
          p_n = p + PW'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  mm_stage_fetch #(.WIDTH(ACT_WIDTH), .N(N), .K(K), .AW(AW), .KW(KW)) u_act_fetch (
    .clk(clk), .rst(rst), .fetch(state == ACT_FETCH), .k(k), .rd_data(act_rd_data),
    .rd_addr(act_rd_addr), .last(act_last), .stage(act_din)
  );

  mm_stage_fetch #(.WIDTH(MAX_PREC), .N(N), .K(K), .AW(AW), .KW(KW)) u_w_fetch (
    .clk(clk), .rst(rst), .fetch(state == W_FETCH), .k(k), .rd_data(w_rd_data),
    .rd_addr(w_rd_addr), .last(w_last), .stage(w_stage)
  );

  for (genvar i = 0; i < N; i++) begin : g_wdin
    logic [MAX_PREC-1:0] word;
    assign word     = w_stage[i*MAX_PREC +: MAX_PREC];
    assign w_din[i] = (state == W_PUSH) && word[p];
  end

  assign active = (state == RUN);
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign err    = err_q;
endmodule

// File: tb/tb_mm_feeder.sv
// Randomized self-checking bench for mm_feeder against a stream/timing model
// built directly from the memory contents and the chosen precision.
module tb_mm_feeder;
  localparam int N = 2, K = 2, AWD = 16, MP = 8, AW = 8;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [3:0] precision = 4'd0;
  logic [AW-1:0] act_rd_addr, w_rd_addr;
  logic [AWD-1:0] act_rd_data;
  logic [MP-1:0] w_rd_data;
  logic [N*AWD-1:0] act_din;
  logic [N-1:0] act_full = '0, w_full = '0, w_din;
  logic wr_en_act, wr_en_w, active, busy, done, err;

  logic [AWD-1:0] act_mem [0:255];
  logic [MP-1:0]  w_mem   [0:255];

  int total = 0, bad = 0;
  int cyc = 0, t0 = 0;
  int done_cyc, first_act, act_cnt, err_cnt, err_cyc, busy_cnt, addr_cnt, bad_wr;
  logic [N*AWD-1:0] aq[$];
  logic [N-1:0]     wq[$];

  mm_feeder #(.ACT_WIDTH(AWD), .N(N), .K(K), .MAX_PREC(MP), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .precision(precision),
    .act_rd_addr(act_rd_addr), .act_rd_data(act_rd_data),
    .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
    .act_din(act_din), .wr_en_act(wr_en_act), .act_full(act_full),
    .w_din(w_din), .wr_en_w(wr_en_w), .w_full(w_full),
    .active(active), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    act_rd_data <= act_mem[act_rd_addr];
    w_rd_data   <= w_mem[w_rd_addr];
  end

  // Collects what the FIFOs and the array would see, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en_act) aq.push_back(act_din);
    if (wr_en_w) wq.push_back(w_din);
    if (wr_en_w && w_full != '0) bad_wr++;
    if (active) begin
      act_cnt++;
      if (first_act < 0) first_act = cyc - t0;
    end
    if (done && done_cyc < 0) done_cyc = cyc - t0;
    if (err) begin
      err_cnt++;
      if (err_cyc < 0) err_cyc = cyc - t0;
    end
    if (busy) busy_cnt++;
    if (act_rd_addr != '0 || w_rd_addr != '0) addr_cnt++;
  end

  task automatic clear_mon();
    aq.delete(); wq.delete();
    done_cyc = -1; first_act = -1; act_cnt = 0; err_cnt = 0; err_cyc = -1;
    busy_cnt = 0; addr_cnt = 0; bad_wr = 0;
  endtask

  function automatic int exp_done(input int prec, input int stalls);
    return 1 + K*(N+2) + K*(N+1+prec) + 2 + K*prec + stalls;
  endfunction

  // Returns -1 when the activation writes match the memory image, else the first bad index.
  function automatic int act_stream_err();
    if (aq.size() != K) return 1000 + aq.size();
    for (int k = 0; k < K; k++) begin
      logic [N*AWD-1:0] e;
      for (int r = 0; r < N; r++) e[r*AWD +: AWD] = act_mem[r*K+k];
      if (aq[k] !== e) return k;
    end
    return -1;
  endfunction

  // Expected weight stream: per step k, bits 0..prec-1 of each column's word, LSB first.
  function automatic int w_stream_err(input int prec);
    if (wq.size() != K*prec) return 1000 + wq.size();
    for (int k = 0; k < K; k++)
      for (int b = 0; b < prec; b++) begin
        logic [N-1:0] e;
        for (int r = 0; r < N; r++) e[r] = w_mem[r*K+k][b];
        if (wq[k*prec+b] !== e) return k*prec + b;
      end
    return -1;
  endfunction

  task automatic run_seq(input int prec, input int sa, input int sw, input int repulse_at,
                         input int reset_at);
    int w_at;
    w_at = K*(N+2) + N + 2 + sa;
    clear_mon();
    @(posedge clk); #1;
    t0 = cyc; start = 1'b1; precision = 4'(prec);
    for (int c = 1; c < 400; c++) begin
      @(posedge clk); #1;
      start = (c == repulse_at);
      if (start) precision = 4'd0;
      act_full = (c >= N+2 && c < N+2+sa) ? 2'b01 : 2'b00;
      w_full   = (c >= w_at && c < w_at+sw) ? 2'b10 : 2'b00;
      rst      = (c == reset_at) ? 1'b0 : 1'b1;
      if (done_cyc >= 0 || (reset_at > 0 && c > reset_at)) break;
    end
    act_full = '0; w_full = '0; rst = 1'b1; start = 1'b0;
  endtask

  task automatic load_spec_mem();
    act_mem[0] = 16'h3C00; act_mem[1] = 16'h4000; act_mem[2] = 16'hBC00; act_mem[3] = 16'h4200;
    w_mem[0] = 8'h05; w_mem[1] = 8'h0A; w_mem[2] = 8'h0F; w_mem[3] = 8'h01;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, active, done, err, wr_en_act, wr_en_w} !== 6'b0) begin
      bad++; $display("[TB] FAIL reset_ctrl: got %b want 000000", {busy, active, done, err, wr_en_act, wr_en_w});
    end
    total++;
    if ({act_rd_addr, w_rd_addr, act_din, w_din} !== '0) begin
      bad++; $display("[TB] FAIL reset_data: got %h want 0", {act_rd_addr, w_rd_addr, act_din, w_din});
    end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    int e;
    load_spec_mem();
    run_seq(4, 0, 0, 0, 0);
    e = act_stream_err(); total++;
    if (e !== -1) begin bad++; $display("[TB] FAIL basic_act: got bad index %0d want -1", e); end
    e = w_stream_err(4); total++;
    if (e !== -1) begin bad++; $display("[TB] FAIL basic_w: got bad index %0d want -1", e); end
    total++;
    if (wq.size() == 8 && {wq[0][1], wq[4][1]} !== 2'b11) begin
      bad++; $display("[TB] FAIL basic_col1_bits: got %b want 11", {wq[0][1], wq[4][1]});
    end
    total++;
    if (act_cnt !== 8) begin bad++; $display("[TB] FAIL basic_active: got %0d want 8", act_cnt); end
    total++;
    if (first_act !== 25) begin bad++; $display("[TB] FAIL basic_first_active: got %0d want 25", first_act); end
    total++;
    if (done_cyc !== 33) begin bad++; $display("[TB] FAIL basic_done: got %0d want 33", done_cyc); end
    total++;
    if (err_cnt !== 0) begin bad++; $display("[TB] FAIL basic_err: got %0d want 0", err_cnt); end
  endtask

  task automatic test_stall();
    int e;
    load_spec_mem();
    run_seq(4, 0, 3, 0, 0);
    e = w_stream_err(4); total++;
    if (e !== -1) begin bad++; $display("[TB] FAIL stall_w: got bad index %0d want -1", e); end
    total++;
    if (bad_wr !== 0) begin bad++; $display("[TB] FAIL stall_wr_gate: got %0d want 0", bad_wr); end
    total++;
    if (done_cyc !== 36) begin bad++; $display("[TB] FAIL stall_done: got %0d want 36", done_cyc); end
  endtask

  task automatic test_bad_prec();
    int precs [2] = '{0, 9};
    for (int i = 0; i < 2; i++) begin
      clear_mon();
      @(posedge clk); #1;
      t0 = cyc; start = 1'b1; precision = 4'(precs[i]);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      total++;
      if (err_cnt !== 1 || err_cyc !== 1) begin
        bad++; $display("[TB] FAIL bad_prec%0d_err: got count %0d at %0d want 1 at 1", precs[i], err_cnt, err_cyc);
      end
      total++;
      if (busy_cnt !== 0 || addr_cnt !== 0) begin
        bad++; $display("[TB] FAIL bad_prec%0d_idle: got busy %0d addr %0d want 0 0", precs[i], busy_cnt, addr_cnt);
      end
    end
  endtask

  task automatic test_reset_run();
    int e;
    load_spec_mem();
    run_seq(4, 0, 0, 0, 28);
    total++;
    if ({busy, active, done, wr_en_act, wr_en_w, act_din, w_din, act_rd_addr, w_rd_addr} !== '0) begin
      bad++; $display("[TB] FAIL reset_run_outputs: got busy %b active %b din %h want all 0", busy, active, act_din);
    end
    run_seq(4, 0, 0, 0, 0);
    e = w_stream_err(4); total++;
    if (e !== -1 || act_stream_err() !== -1) begin
      bad++; $display("[TB] FAIL reset_run_restart_streams: got bad index %0d want -1", e);
    end
    total++;
    if (done_cyc !== 33) begin bad++; $display("[TB] FAIL reset_run_restart_done: got %0d want 33", done_cyc); end
  endtask

  task automatic test_back_to_back();
    int e;
    load_spec_mem();
    run_seq(4, 0, 0, 13, 0);
    e = w_stream_err(4); total++;
    if (e !== -1) begin bad++; $display("[TB] FAIL repulse_w: got bad index %0d want -1", e); end
    total++;
    if (err_cnt !== 0 || done_cyc !== 33) begin
      bad++; $display("[TB] FAIL repulse_timing: got err %0d done %0d want 0 33", err_cnt, done_cyc);
    end
  endtask

  task automatic test_prec8();
    int e;
    for (int i = 0; i < N*K; i++) begin
      act_mem[i] = 16'($urandom); w_mem[i] = 8'($urandom);
    end
    run_seq(8, 0, 0, 0, 0);
    e = w_stream_err(8); total++;
    if (e !== -1) begin bad++; $display("[TB] FAIL prec8_w: got bad index %0d want -1", e); end
    total++;
    if (act_cnt !== K*8 || done_cyc !== exp_done(8, 0)) begin
      bad++; $display("[TB] FAIL prec8_timing: got active %0d done %0d want %0d %0d", act_cnt, done_cyc, K*8, exp_done(8, 0));
    end
  endtask

  task automatic test_random();
    int prec, sa, sw, e;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < N*K; i++) begin
        act_mem[i] = 16'($urandom); w_mem[i] = 8'($urandom);
      end
      prec = $urandom_range(1, 8); sa = $urandom_range(0, 3); sw = $urandom_range(0, 3);
      run_seq(prec, sa, sw, 0, 0);
      e = act_stream_err(); total++;
      if (e !== -1) begin bad++; $display("[TB] FAIL rand%0d_act: got bad index %0d want -1", it, e); end
      e = w_stream_err(prec); total++;
      if (e !== -1) begin bad++; $display("[TB] FAIL rand%0d_w: got bad index %0d want -1 (p=%0d)", it, e, prec); end
      total++;
      if (act_cnt !== K*prec || done_cyc !== exp_done(prec, sa+sw) || bad_wr !== 0) begin
        bad++;
        $display("[TB] FAIL rand%0d_timing: got active %0d done %0d gate %0d want %0d %0d 0",
                 it, act_cnt, done_cyc, bad_wr, K*prec, exp_done(prec, sa+sw));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin act_mem[i] = '0; w_mem[i] = '0; end
    clear_mon();
    test_reset();
    test_basic();
    test_stall();
    test_bad_prec();
    test_reset_run();
    test_back_to_back();
    test_prec8();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
